// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared defaults, requester indices and width helper for the ALU writeback arbiter
package alu_wb_pkg;
    localparam int NUM_REQ_DEF = 8;
    localparam int MAX_LSU_STREAK_DEF = 4;
    localparam int SIMD0 = 0;
    localparam int SIMD1 = 1;
    localparam int SIMD2 = 2;
    localparam int SIMD3 = 3;
    localparam int SIMF0 = 4;
    localparam int SIMF1 = 5;
    localparam int SIMF2 = 6;
    localparam int SIMF3 = 7;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
    function automatic int clog2(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rfa_rr_pick.sv
// rfa_rr_pick: combinational rotating-priority picker starting the scan at ptr_i
module rfa_rr_pick import alu_wb_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   idx_o,
    output logic               any_o
);
    localparam logic [SEL_W:0] NR = (SEL_W+1)'(NUM_REQ);
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0] sum;
    assign any_o = |req_i;
    // Rotate so the pointer lands at bit 0, find the nearest request, then map back.
    always_comb begin
        rot = NUM_REQ'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
        sum = {1'b0, ptr_i} + {1'b0, off};
        idx_o = sum >= NR ? SEL_W'(sum - NR) : sum[SEL_W-1:0];
        gnt_o = any_o ? NUM_REQ'(1) << idx_o : '0;
    end
endmodule

// File: rtl/rfa_wb_arbiter.sv
// rfa_wb_arbiter: grants one ALU writeback queue or the LSU per cycle, LSU priority bounded by a streak limit
module rfa_wb_arbiter import alu_wb_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int MAX_LSU_STREAK = MAX_LSU_STREAK_DEF,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] in_queue_entry_valid,
    input  logic               in_lsu_wr_req,
    output logic [NUM_REQ-1:0] out_queue_entry_serviced,
    output logic               out_lsu_wr_grant,
    output logic               out_wb_valid,
    output logic               out_wb_is_lsu,
    output logic [SEL_W-1:0]   out_wb_select
);
    localparam int STW = clog2(MAX_LSU_STREAK + 1);
    localparam logic [STW-1:0] STREAK_MAX = STW'(MAX_LSU_STREAK);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REQ - 1);
    wb_src_e src;
    logic [SEL_W-1:0] rr_q, rr_d, sel_q, sel_d, pick_idx;
    logic [STW-1:0] streak_q, streak_d;
    logic valid_q, lsu_q, pick_any;
    logic [NUM_REQ-1:0] pick_gnt;
    rfa_rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
        .req_i(in_queue_entry_valid),
        .ptr_i(rr_q),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );
    // The streak only grows while an ALU waits, so it never passes STREAK_MAX.
    always_comb begin
        src = rst ? WB_NONE
            : (in_lsu_wr_req && (!pick_any || streak_q < STREAK_MAX)) ? WB_LSU
            : pick_any ? WB_ALU : WB_NONE;
        rr_d = src == WB_ALU ? (pick_idx == LAST ? '0 : pick_idx + 1'b1) : rr_q;
        streak_d = (src == WB_LSU && pick_any) ? streak_q + 1'b1 : '0;
        sel_d = src == WB_ALU ? pick_idx : sel_q;
    end
    assign out_queue_entry_serviced = src == WB_ALU ? pick_gnt : '0;
    assign out_lsu_wr_grant = src == WB_LSU;
    assign out_wb_valid = valid_q;
    assign out_wb_is_lsu = lsu_q;
    assign out_wb_select = sel_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            streak_q <= '0;
            valid_q <= 1'b0;
            lsu_q <= 1'b0;
            sel_q <= '0;
        end else begin
            rr_q <= rr_d;
            streak_q <= streak_d;
            valid_q <= src != WB_NONE;
            lsu_q <= src == WB_LSU;
            sel_q <= sel_d;
        end
    end
endmodule

// File: tb/tb_rfa_wb_arbiter.sv
// tb_rfa_wb_arbiter: directed vectors, literal expectations plus a per-cycle behavioural model check
module tb_rfa_wb_arbiter;
    import alu_wb_pkg::*;
    localparam int N = 8;
    localparam int MAXS = 4;
    logic clk, rst, lsu, grant, wb_valid, wb_is_lsu;
    logic [N-1:0] valid, serv;
    logic [3:0] wb_sel;
    int checks = 0;
    int failures = 0;
    int m_rr, m_st, e_sel, alu_k, exp_serv;
    bit primed, e_v, e_l, lsu_g, any_v;

    rfa_wb_arbiter #(.NUM_REQ(N), .MAX_LSU_STREAK(MAXS), .SEL_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_queue_entry_valid(valid),
        .in_lsu_wr_req(lsu),
        .out_queue_entry_serviced(serv),
        .out_lsu_wr_grant(grant),
        .out_wb_valid(wb_valid),
        .out_wb_is_lsu(wb_is_lsu),
        .out_wb_select(wb_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scan requesters from the priority pointer, LSU wins unless an ALU has waited out the streak.
    always @(negedge clk) begin
        any_v = valid != 0;
        lsu_g = !rst && lsu && (!any_v || m_st < MAXS);
        alu_k = -1;
        if (!rst && !lsu_g && any_v)
            for (int k = 0; k < N; k++)
                if (alu_k < 0 && ((valid >> ((m_rr + k) % N)) & 1) != 0) alu_k = (m_rr + k) % N;
        exp_serv = alu_k >= 0 ? (1 << alu_k) : 0;
        chk("model_serviced", int'(serv), exp_serv);
        chk("model_lsu_grant", int'(grant), int'(lsu_g));
        if (primed) begin
            chk("model_wb_valid", int'(wb_valid), int'(e_v));
            chk("model_wb_is_lsu", int'(wb_is_lsu), int'(e_l));
            chk("model_wb_select", int'(wb_sel), e_sel);
        end
        if (rst) begin
            m_rr = 0; m_st = 0; e_v = 0; e_l = 0; e_sel = 0;
        end else begin
            e_v = lsu_g || alu_k >= 0;
            e_l = lsu_g;
            if (alu_k >= 0) begin
                e_sel = alu_k; m_rr = (alu_k + 1) % N; m_st = 0;
            end else if (lsu_g) m_st = any_v ? (m_st < MAXS ? m_st + 1 : MAXS) : 0;
            else m_st = 0;
        end
        primed = 1;
    end

    task automatic tick(input logic [N-1:0] v, input logic l, input logic r);
        @(posedge clk);
        #1;
        valid = v; lsu = l; rst = r;
        @(negedge clk);
        #1;
    endtask

    typedef struct { logic [N-1:0] v; logic l; } vec_t;
    vec_t tbl[12] = '{'{8'h00, 1'b1}, '{8'hF0, 1'b1}, '{8'hF0, 1'b1}, '{8'hF0, 1'b1},
                      '{8'hF0, 1'b1}, '{8'hF0, 1'b1}, '{8'h0F, 1'b0}, '{8'h55, 1'b0},
                      '{8'hAA, 1'b1}, '{8'hFF, 1'b0}, '{8'h00, 1'b0}, '{8'h3C, 1'b1}};
    int exp_sel[4] = '{0, 7, 0, 7};
    int exp_pat[6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        primed = 0; m_rr = 0; m_st = 0;
        rst = 1'b1; valid = '0; lsu = 1'b0;
        tick(8'hFF, 1'b1, 1'b1);
        tick(8'hFF, 1'b1, 1'b1);
        chk("rst_serviced", int'(serv), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        tick(8'hFF, 1'b0, 1'b0);
        chk("rst_first_alu0", int'(serv), 1 << SIMD0);
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(8'h81, 1'b0, 1'b0);
            chk("rr_wrap_serviced", int'(serv), (i % 2 == 0) ? 8'h01 : 8'h80);
            if (i > 0) chk("rr_wrap_select", int'(wb_sel), exp_sel[i-1]);
        end
        tick(8'h00, 1'b0, 1'b0);
        chk("rr_wrap_select_last", int'(wb_sel), exp_sel[3]);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h04, 1'b0, 1'b0);
        chk("skip_first", int'(serv), 8'h04);
        tick(8'h06, 1'b0, 1'b0);
        chk("skip_second", int'(serv), 8'h02);
        tick(8'h06, 1'b0, 1'b0);
        chk("skip_third", int'(serv), 8'h04);
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(8'h08, 1'b1, 1'b0);
            chk("starve_lsu", int'(grant), exp_pat[i]);
            chk("starve_alu", int'(serv), exp_pat[i] != 0 ? 0 : (1 << SIMD3));
            if (i > 0) chk("starve_is_lsu", int'(wb_is_lsu), exp_pat[i-1]);
        end
        tick(8'h00, 1'b0, 1'b0);
        chk("starve_is_lsu_last", int'(wb_is_lsu), exp_pat[5]);
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(8'h00, 1'b1, 1'b0);
            chk("lsu_alone", int'(grant), 1);
        end
        for (int i = 0; i < 5; i++) begin
            tick(8'h08, 1'b1, 1'b0);
            chk("lsu_then_alu", int'(serv), i < 4 ? 0 : 8'h08);
        end
        tick(8'h21, 1'b0, 1'b0);
        chk("mid_pre", int'(serv), 1 << SIMF1);
        tick(8'h21, 1'b0, 1'b1);
        chk("mid_rst_serviced", int'(serv), 0);
        tick(8'h21, 1'b0, 1'b0);
        chk("mid_after_serviced", int'(serv), 8'h01);
        chk("mid_after_wb_valid", int'(wb_valid), 0);
        for (int r = 0; r < 2; r++)
            foreach (tbl[i]) tick(tbl[i].v, tbl[i].l, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rfa_wb_arbiter.md
Name: rfa_wb_arbiter

Overview:
- Service end of the ALU writeback-queue protocol.
- Each SIMD/SIMF ALU raises rfa_queue_entry_valid while its writeback queue head is ready to retire.
- This block grants at most one requester per cycle and pulses that requester's rfa_queue_entry_serviced so the queue pops.
- It arbitrates the LSU writeback port against the ALUs, with LSU priority bounded by a starvation limit, and registers the winner for the register-file write mux.

Parameters:
- NUM_REQ, 8: number of ALU writeback queues (SIMD0-3, SIMF0-3); legal range 2..16.
- MAX_LSU_STREAK, 4: maximum consecutive LSU grants while any ALU request is pending; must be >= 1.
- SEL_W, 4: width of the encoded winner index; must satisfy 2**SEL_W >= NUM_REQ.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_queue_entry_valid  in  NUM_REQ  per-ALU rfa_queue_entry_valid.
- in_lsu_wr_req  in  1  LSU writeback request.
- out_queue_entry_serviced  out  NUM_REQ  one-hot or zero; per-ALU rfa_queue_entry_serviced.
- out_lsu_wr_grant  out  1  LSU granted this cycle.
- out_wb_valid  out  1  registered: a grant occurred last cycle.
- out_wb_is_lsu  out  1  registered: last cycle's grant went to the LSU.
- out_wb_select  out  SEL_W  registered: index of last cycle's ALU winner.

Behaviour:
- **Grants are combinational** from the inputs and state in the same cycle. The requester samples serviced at posedge clk and pops its queue head. The next head's valid is then evaluated fresh, with no blanking cycle.
- **Outputs during rst:**
  - out_queue_entry_serviced = 0 and out_lsu_wr_grant = 0 (forced by rst).
  - out_wb_valid, out_wb_is_lsu and out_wb_select are 0 after the reset edge.
- **State:**
  - rr_ptr: SEL_W bits, index with highest ALU priority; reset value 0.
  - lsu_streak: clog2(MAX_LSU_STREAK+1) bits; reset value 0.
- **Decision each cycle** (alu_any = |in_queue_entry_valid):
  - If in_lsu_wr_req and (!alu_any or lsu_streak < MAX_LSU_STREAK): grant the LSU.
  - Else if alu_any: grant the first set bit of in_queue_entry_valid, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Else: no grant.
- **Exclusivity:** exactly one of {LSU, one ALU, none} is granted. out_queue_entry_serviced is never multi-hot. The LSU grant and any ALU serviced bit are never asserted together.
- **Updates at posedge** (rst has priority over everything):
  - ALU k granted: rr_ptr <= (k+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0. lsu_streak <= 0.
  - LSU granted while alu_any: lsu_streak <= lsu_streak+1, saturating at MAX_LSU_STREAK.
  - LSU granted while !alu_any: lsu_streak <= 0.
  - No grant: rr_ptr unchanged. lsu_streak <= 0.
  - out_wb_valid <= any grant. out_wb_is_lsu <= LSU grant. out_wb_select <= k if an ALU was granted, else holds its previous value.
- **Starvation bound:** when lsu_streak == MAX_LSU_STREAK, a pending ALU wins even if the LSU requests. This resets lsu_streak, so the LSU regains priority the following cycle.
- **Fairness:** every continuously valid ALU is serviced within NUM_REQ*(MAX_LSU_STREAK+1) cycles.
- **Reset mid-operation:** any grant in that cycle is suppressed, so no pop occurs. State returns to reset values.
- **Request drop:** a requester dropping valid without a grant is legal and has no side effects.

Decomposition:
- Package alu_wb_pkg:
  - Default NUM_REQ and MAX_LSU_STREAK.
  - Requester index constants SIMD0..SIMF3.
  - SEL_W derivation function (clog2).
- One sub-module, rfa_rr_pick: combinational rotating-priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any.
- The top level holds rr_ptr, lsu_streak, the LSU/ALU decision and the output registers.

Test Plan:
- **Reset:** hold rst 2 cycles with all requests high → serviced = 0, grant = 0, out_wb_valid = 0; rr_ptr = 0 observed via the first grant going to ALU0.
- **Round robin with wrap:** valid = 8'b1000_0001 held, no LSU → serviced sequence 0x01, 0x80, 0x01, 0x80; out_wb_select one cycle later is 0, 7, 0, 7.
- **Pointer skip:** after granting ALU2, valid = 8'b0000_0110 → ALU1 is not granted until rr_ptr passes it; grant order is 2, then 1, then 2.
- **LSU starvation bound:** LSU req held high, valid = 0x08, MAX_LSU_STREAK = 4 → LSU granted 4 cycles, ALU3 granted in cycle 5, LSU in cycle 6; out_wb_is_lsu pattern 1,1,1,1,0,1.
- **LSU alone:** LSU req with no ALU valid for 10 cycles → granted every cycle; lsu_streak stays 0; a later ALU arrival still waits a full 4 LSU grants.
- **Mid-operation reset:** rst asserted while ALU5 valid → no serviced pulse in that cycle; after release, the first grant goes to the lowest set index ≥ 0.
